sal_axi_traffic_gen: RTL and testbench
======================================

// Module: sal_axi_traffic_gen
// PURPOSE
// Synthesizable AXI master traffic generator driving SAL_DDR_CTRL AR/R/AW/W/B channels in simulation
//   and FPGA bring-up; replaces hand-coded per-transfer stimulus.
// Issues NUM_TXN INCR bursts from base_addr with fixed stride, up to MAX_OUTST in flight per direction.
// Mode 2 writes a deterministic pattern, reads it back, and counts mismatches.
// PARAMETERS
// ADDR_W       32   AXI address width
// DATA_W       128  AXI data width; multiple of 32
// ID_W         4    AXI ID width
// NUM_TXN      16   bursts per direction per run (1..65535)
// MAX_OUTST    4    max outstanding addresses per direction (1..16)
// ADDR_STRIDE  64   byte offset between consecutive burst start addresses
// PORTS
// clk        in   1       clock
// rst_n      in   1       reset, asynchronous, active-high
// start      in   1       one-cycle run request; ignored while busy
// mode       in   2       0=read only, 1=write only, 2=write then read+check, 3=reserved
// base_addr  in   ADDR_W  first burst address; sampled on accepted start
// burst_len  in   4       AXI len (beats-1); sampled on accepted start
// arvalid/arready  out/in 1; arid out ID_W; araddr out ADDR_W; arlen out 4
// rvalid in 1; rready out 1; rid in ID_W; rdata in DATA_W; rlast in 1
// awvalid/awready  out/in 1; awid out ID_W; awaddr out ADDR_W; awlen out 4
// wvalid out 1; wready in 1; wdata out DATA_W; wlast out 1
// bvalid in 1; bready out 1; bid in ID_W
// busy out 1; done out 1 (one-cycle pulse); err_cnt out 16
// BEHAVIOUR
// Reset (rst_n=1, async): all valids, rready, bready, busy, done = 0; counters, err_cnt = 0; state IDLE.
// Reset mid-run aborts immediately; no completion pulse.
// Burst size is always DATA_W/8 bytes; burst type is always INCR.
// Txn k (0..NUM_TXN-1): addr = base_addr + k*ADDR_STRIDE (mod 2^ADDR_W, wraps silently).
//   id = k mod 2^ID_W.
// Pattern beat b of txn k: 32-bit word (addr_k + b*DATA_W/8) ^ 32'hA5A5_5A5A, replicated to DATA_W.
// FSM states and transitions:
//   IDLE -> WR on start with mode 1/2; IDLE -> RD on start with mode 0.
//   IDLE: start with mode 3 pulses done next cycle; no traffic, busy stays 0.
//   WR -> WAIT_B when all NUM_TXN AW accepted.
//   WAIT_B -> RD (mode 2) or DONE (mode 1) when B count = NUM_TXN.
//   RD -> WAIT_R when all AR accepted.
//   WAIT_R -> DONE when NUM_TXN rlast beats received.
//   DONE -> IDLE after 1 cycle; done=1 in DONE.
// busy = 1 in every state except IDLE, i.e. from cycle after accepted start until done cycle inclusive.
// Address issue: valid asserted only when issued<NUM_TXN and outstanding<MAX_OUTST.
//   valid/addr/id/len held stable until ready; no combinational path ready->valid.
// Outstanding counters: +1 on AW/AR handshake, -1 on B / R-last handshake.
//   Same-cycle +1 and -1 leaves the count unchanged.
// W channel: beats for txn k start only after AW k accepted; beats are in order; wlast on beat burst_len.
//   wvalid may be asserted in the cycle after the AW handshake.
// rready and bready are held 1 while busy.
// Read check (mode 2 only; mode 0 checks nothing), in-order return expected. +1 err per beat if:
//   rid != expected id; rdata != pattern; rlast != (beat==burst_len).
// Mode 2 B check: +1 err if bid != expected id. err_cnt saturates at 16'hFFFF.
// err_cnt clears on accepted start and holds after done.
// TESTING
// Mode 1, NUM_TXN=4, len=3, base 0x1000, stride 64, ready tied 1 -> AW at 0x1000/40/80/C0;
//   16 W beats; done after 4th B.
// Mode 2 against ideal memory model -> err_cnt=0 and done=1.
// Mode 2, model flips bit 0 of 1 read beat -> err_cnt=1.
// arready low 20 cycles, MAX_OUTST=2, delayed R -> never >2 outstanding;
//   araddr stable while arvalid&&!arready.
// base 0xFFFF_FFC0, stride 64, NUM_TXN=2 -> second addr 0x0000_0000.
// rst_n pulsed during WAIT_R -> all valids 0 same cycle, busy=0, no done;
//   a new start then runs normally.

Source files
------------

// File: rtl/sal_axi_traffic_gen.sv
// AXI master traffic generator: INCR bursts from a base address with a fixed stride,
// bounded outstanding addresses per direction, optional write/read-back pattern check.
module sal_axi_traffic_gen #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int ID_W        = 4,
  parameter int NUM_TXN     = 16,
  parameter int MAX_OUTST   = 4,
  parameter int ADDR_STRIDE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        burst_len,
  output logic              arvalid,
  input  logic              arready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [ID_W-1:0]   bid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = 17;
  localparam int OUT_W = 5;
  localparam logic [CNT_W-1:0]  NUM_C    = CNT_W'(NUM_TXN);
  localparam logic [OUT_W-1:0]  MAX_C    = OUT_W'(MAX_OUTST);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(ADDR_STRIDE);
  localparam logic [ADDR_W-1:0] BEAT_C   = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WAIT_B = 3'd2,
    S_RD     = 3'd3,
    S_WAIT_R = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a) ^ 32'hA5A5_5A5A;
    return {(DATA_W / 32){w}};
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_mode;
  logic [3:0]          r_len;
  logic                r_done3;
  logic [15:0]         r_err;

  logic [CNT_W-1:0]    r_aw_cnt, r_w_txn, r_b_cnt, r_ar_cnt, r_r_txn;
  logic [OUT_W-1:0]    r_wr_outst, r_rd_outst;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [ADDR_W-1:0]   r_w_taddr, r_w_baddr, r_r_taddr, r_r_baddr;
  logic [3:0]          r_w_beat, r_r_beat;
  logic                r_awvalid, r_arvalid;

  logic                w_start_ok;
  logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [CNT_W-1:0]    w_aw_cnt_nxt, w_ar_cnt_nxt;
  logic [OUT_W-1:0]    w_wr_outst_nxt, w_rd_outst_nxt;
  logic                w_r_bad, w_b_bad, w_err_inc;

  // Valid/ready: a transfer happens on a cycle where valid and ready are both high at
  // the clock edge; address valids come from registers only and, once raised, hold
  // valid/addr/id/len unchanged until that transfer.
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) || r_done3;
  assign rready    = busy;
  assign bready    = busy;
  assign err_cnt   = r_err;
  assign dbg_state = r_state;

  assign awvalid = r_awvalid;
  assign awaddr  = r_awaddr;
  assign awid    = ID_W'(r_aw_cnt);
  assign awlen   = r_len;
  assign arvalid = r_arvalid;
  assign araddr  = r_araddr;
  assign arid    = ID_W'(r_ar_cnt);
  assign arlen   = r_len;

  assign wvalid  = ((r_state == S_WR) || (r_state == S_WAIT_B)) && (r_w_txn < r_aw_cnt);
  assign wdata   = pattern(r_w_baddr);
  assign wlast   = (r_w_beat == r_len);

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_aw_hs    = r_awvalid && awready;
  assign w_w_hs     = wvalid && wready;
  assign w_b_hs     = bvalid && bready && ((r_state == S_WR) || (r_state == S_WAIT_B));
  assign w_ar_hs    = r_arvalid && arready;
  assign w_r_hs     = rvalid && rready && ((r_state == S_RD) || (r_state == S_WAIT_R));

  assign w_aw_cnt_nxt   = w_start_ok ? '0 : r_aw_cnt + CNT_W'(w_aw_hs);
  assign w_ar_cnt_nxt   = w_start_ok ? '0 : r_ar_cnt + CNT_W'(w_ar_hs);
  assign w_wr_outst_nxt = w_start_ok ? '0 : r_wr_outst + OUT_W'(w_aw_hs) - OUT_W'(w_b_hs);
  assign w_rd_outst_nxt = w_start_ok ? '0 :
                          r_rd_outst + OUT_W'(w_ar_hs) - OUT_W'(w_r_hs && rlast);

  // Read data is checked in order against the pattern of the expected beat address.
  assign w_r_bad   = (rid != ID_W'(r_r_txn)) || (rdata != pattern(r_r_baddr)) ||
                     (rlast != (r_r_beat == r_len));
  assign w_b_bad   = (bid != ID_W'(r_b_cnt));
  assign w_err_inc = (r_mode == 2'd2) && ((w_r_hs && w_r_bad) || (w_b_hs && w_b_bad));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'd0)      w_state_nxt = S_RD;
          else if (mode != 2'd3) w_state_nxt = S_WR;
        end
      end
      S_WR:     if (r_aw_cnt == NUM_C) w_state_nxt = S_WAIT_B;
      S_WAIT_B: if (r_b_cnt == NUM_C)  w_state_nxt = (r_mode == 2'd2) ? S_RD : S_DONE;
      S_RD:     if (r_ar_cnt == NUM_C) w_state_nxt = S_WAIT_R;
      S_WAIT_R: if (r_r_txn == NUM_C)  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_len   <= '0;
      r_done3 <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done3 <= w_start_ok && (mode == 2'd3);
      if (w_start_ok) begin
        r_mode <= mode;
        r_len  <= burst_len;
        r_err  <= '0;
      end else if (w_err_inc && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  // Write direction: AW issue, W beats trailing accepted AWs, B collection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_awvalid  <= 1'b0;
      r_awaddr   <= '0;
      r_aw_cnt   <= '0;
      r_wr_outst <= '0;
      r_w_txn    <= '0;
      r_w_beat   <= '0;
      r_w_taddr  <= '0;
      r_w_baddr  <= '0;
      r_b_cnt    <= '0;
    end else begin
      r_aw_cnt   <= w_aw_cnt_nxt;
      r_wr_outst <= w_wr_outst_nxt;
      r_awvalid  <= (w_state_nxt == S_WR) && (w_aw_cnt_nxt < NUM_C) && (w_wr_outst_nxt < MAX_C);
      if (w_start_ok) begin
        r_awaddr  <= base_addr;
        r_w_txn   <= '0;
        r_w_beat  <= '0;
        r_w_taddr <= base_addr;
        r_w_baddr <= base_addr;
        r_b_cnt   <= '0;
      end else begin
        if (w_aw_hs) r_awaddr <= r_awaddr + STRIDE_C;
        if (w_w_hs) begin
          if (wlast) begin
            r_w_txn   <= r_w_txn + 1'b1;
            r_w_beat  <= '0;
            r_w_taddr <= r_w_taddr + STRIDE_C;
            r_w_baddr <= r_w_taddr + STRIDE_C;
          end else begin
            r_w_beat  <= r_w_beat + 4'd1;
            r_w_baddr <= r_w_baddr + BEAT_C;
          end
        end
        if (w_b_hs) r_b_cnt <= r_b_cnt + 1'b1;
      end
    end
  end

  // Read direction: AR issue and in-order R tracking.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_arvalid  <= 1'b0;
      r_araddr   <= '0;
      r_ar_cnt   <= '0;
      r_rd_outst <= '0;
      r_r_txn    <= '0;
      r_r_beat   <= '0;
      r_r_taddr  <= '0;
      r_r_baddr  <= '0;
    end else begin
      r_ar_cnt   <= w_ar_cnt_nxt;
      r_rd_outst <= w_rd_outst_nxt;
      r_arvalid  <= (w_state_nxt == S_RD) && (w_ar_cnt_nxt < NUM_C) && (w_rd_outst_nxt < MAX_C);
      if (w_start_ok) begin
        r_araddr  <= base_addr;
        r_r_txn   <= '0;
        r_r_beat  <= '0;
        r_r_taddr <= base_addr;
        r_r_baddr <= base_addr;
      end else begin
        if (w_ar_hs) r_araddr <= r_araddr + STRIDE_C;
        if (w_r_hs) begin
          if (rlast) begin
            r_r_txn   <= r_r_txn + 1'b1;
            r_r_beat  <= '0;
            r_r_taddr <= r_r_taddr + STRIDE_C;
            r_r_baddr <= r_r_taddr + STRIDE_C;
          end else begin
            r_r_beat  <= r_r_beat + 4'd1;
            r_r_baddr <= r_r_baddr + BEAT_C;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// Bench for sal_axi_traffic_gen: AXI slave/memory model, expected-queue scoreboard
// on AW/W/AR/done, directed runs for each mode plus stall, wrap and mid-run reset.
module tb_sal_axi_traffic_gen;

  localparam int ADDR_W = 32, DATA_W = 128, ID_W = 4;
  localparam int NUM_TXN = 4, MAX_OUTST = 2, STRIDE = 64;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [1:0]        mode;
  logic [31:0]       base_addr;
  logic [3:0]        burst_len;
  logic              arvalid, arready, rvalid, rready, rlast;
  logic [ID_W-1:0]   arid, rid, awid, bid;
  logic [31:0]       araddr, awaddr;
  logic [3:0]        arlen, awlen;
  logic [127:0]      rdata, wdata;
  logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic              busy, done;
  logic [15:0]       err_cnt;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  sal_axi_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_TXN(NUM_TXN),
    .MAX_OUTST(MAX_OUTST), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .burst_len(burst_len),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .busy(busy), .done(done), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  int n_tests = 0, n_fail = 0;

  logic [39:0]  exp_aw_q[$];
  logic [39:0]  exp_ar_q[$];
  logic [128:0] exp_w_q[$];
  logic [16:0]  exp_done_q[$];
  bit           got_done;
  logic [39:0]  e40;
  logic [128:0] e129;
  logic [16:0]  e17;

  logic [31:0]     aw_addr_q[$];
  logic [ID_W-1:0] aw_id_q[$];
  logic [ID_W-1:0] b_q[$];
  logic [39:0]     ar_q[$];
  logic [31:0]     aw_log[$];
  logic [127:0]    mem [logic [31:0]];
  int w_beat_i, r_beat_i, r_gap, r_gap_cfg, ar_stall, flip_idx, r_beat_total;
  int ar_outst, max_ar_outst, stab_err;
  bit prev_stall;
  logic [31:0] prev_araddr, ra;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {4{a ^ 32'hA5A5_5A5A}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an unexpected event, required none", name);
  endtask

  // Monitor and slave bookkeeping: handshakes seen here are the ones the next edge takes.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) flag_unexpected("aw");
        else begin
          e40 = exp_aw_q.pop_front();
          check("awaddr", awaddr, e40[31:0]);
          check("awid", awid, e40[35:32]);
          check("awlen", awlen, e40[39:36]);
        end
        aw_log.push_back(awaddr);
        aw_addr_q.push_back(awaddr);
        aw_id_q.push_back(awid);
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) flag_unexpected("w");
        else begin
          e129 = exp_w_q.pop_front();
          check("wdata", wdata, e129[127:0]);
          check("wlast", wlast, e129[128]);
        end
        if (aw_addr_q.size() > 0) begin
          mem[aw_addr_q[0] + 32'(w_beat_i * 16)] = wdata;
          if (wlast) begin
            void'(aw_addr_q.pop_front());
            b_q.push_back(aw_id_q.pop_front());
            w_beat_i = 0;
          end else w_beat_i++;
        end
      end
      if (bvalid && bready && b_q.size() > 0) void'(b_q.pop_front());
      if (rvalid && rready && ar_q.size() > 0) begin
        r_beat_total++;
        if (rlast) begin
          void'(ar_q.pop_front());
          r_beat_i = 0;
          r_gap = r_gap_cfg;
          ar_outst--;
        end else r_beat_i++;
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) flag_unexpected("ar");
        else begin
          e40 = exp_ar_q.pop_front();
          check("araddr", araddr, e40[31:0]);
          check("arid", arid, e40[35:32]);
          check("arlen", arlen, e40[39:36]);
        end
        if (ar_q.size() == 0) r_gap = r_gap_cfg;
        ar_q.push_back({arlen, arid, araddr});
        ar_outst++;
        if (ar_outst > max_ar_outst) max_ar_outst = ar_outst;
      end
      if (prev_stall && (!arvalid || araddr != prev_araddr)) stab_err++;
      prev_stall  = arvalid && !arready;
      prev_araddr = araddr;
      if (done) begin
        got_done = 1;
        if (exp_done_q.size() == 0) flag_unexpected("done");
        else begin
          e17 = exp_done_q.pop_front();
          check("err_cnt_at_done", err_cnt, e17[15:0]);
          check("busy_at_done", busy, e17[16]);
        end
      end
    end
  end

  // Slave drive: responses for the next cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      ar_q.delete(); b_q.delete(); aw_addr_q.delete(); aw_id_q.delete();
      w_beat_i = 0; r_beat_i = 0; r_gap = 0; ar_outst = 0; prev_stall = 0;
      rvalid = 0; rlast = 0; rid = '0; rdata = '0; bvalid = 0; bid = '0; arready = 0;
    end else begin
      arready = (ar_stall == 0);
      if (ar_stall > 0) ar_stall--;
      bvalid = (b_q.size() > 0);
      bid    = bvalid ? b_q[0] : '0;
      if (ar_q.size() > 0 && r_gap == 0) begin
        ra     = ar_q[0][31:0] + 32'(r_beat_i * 16);
        rvalid = 1;
        rid    = ar_q[0][35:32];
        rdata  = mem.exists(ra) ? mem[ra] : '0;
        if (r_beat_total == flip_idx) rdata[0] = ~rdata[0];
        rlast  = (4'(r_beat_i) == ar_q[0][39:36]);
      end else begin
        rvalid = 0; rlast = 0; rid = '0; rdata = '0;
        if (r_gap > 0) r_gap--;
      end
    end
  end

  task automatic push_addr_exp(input logic [1:0] m, input logic [31:0] base, input logic [3:0] len);
    for (int k = 0; k < NUM_TXN; k++) begin
      logic [31:0] a;
      a = base + 32'(k * STRIDE);
      if (m == 2'd1 || m == 2'd2) begin
        exp_aw_q.push_back({len, 4'(k), a});
        for (int b = 0; b <= int'(len); b++)
          exp_w_q.push_back({(4'(b) == len), pat(a + 32'(b * 16))});
      end
      if (m == 2'd0 || m == 2'd2) exp_ar_q.push_back({len, 4'(k), a});
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [31:0] base, input logic [3:0] len);
    @(posedge clk); #1;
    start = 1; mode = m; base_addr = base; burst_len = len;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input string name, input logic [1:0] m, input logic [31:0] base,
                     input logic [3:0] len, input int stall, input int gap, input int flip,
                     input logic [15:0] exp_err);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_done_q.delete();
    aw_log.delete();
    push_addr_exp(m, base, len);
    exp_done_q.push_back({(m != 2'd3), exp_err});
    r_gap_cfg = gap; ar_stall = stall; flip_idx = flip; r_beat_total = 0;
    got_done = 0; max_ar_outst = 0; stab_err = 0;
    pulse_start(m, base, len);
    @(negedge clk);
    check({name, "_busy_after_start"}, busy, (m != 2'd3));
    for (int c = 0; c < 3000 && !got_done; c++) @(negedge clk);
    if (!got_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no done pulse, required done", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_left_aw_w_ar"}, exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
    check({name, "_err_hold"}, err_cnt, exp_err);
    check({name, "_idle_after"}, busy, 1'b0);
  endtask

  task automatic reset_midrun();
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_done_q.delete();
    push_addr_exp(2'd0, 32'h4000, 4'd3);
    r_gap_cfg = 8; ar_stall = 0; flip_idx = -1; got_done = 0;
    pulse_start(2'd0, 32'h4000, 4'd3);
    for (int c = 0; c < 500 && exp_ar_q.size() != 0; c++) @(negedge clk);
    check("rst_ar_all_issued", exp_ar_q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1;
    #1;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (20) @(negedge clk);
    check("rst_no_done", got_done, 1'b0);
  endtask

  initial begin
    rst_n = 1; start = 0; mode = 0; base_addr = 0; burst_len = 0;
    awready = 1; wready = 1; arready = 0;
    rvalid = 0; rlast = 0; rid = '0; rdata = '0; bvalid = 0; bid = '0;
    r_gap_cfg = 0; ar_stall = 0; flip_idx = -1; r_beat_total = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_awvalid", awvalid, 1'b0);
    check("reset_arvalid", arvalid, 1'b0);
    check("reset_wvalid", wvalid, 1'b0);
    check("reset_rready", rready, 1'b0);
    check("reset_bready", bready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err_cnt", err_cnt, 16'h0);
    rst_n = 0;
    repeat (2) @(negedge clk);

    run("m1_write", 2'd1, 32'h0000_1000, 4'd3, 0, 0, -1, 16'd0);
    check("m1_aw0", aw_log[0], 32'h0000_1000);
    check("m1_aw3", aw_log[3], 32'h0000_10C0);

    run("m2_clean", 2'd2, 32'h0000_2000, 4'd3, 0, 2, -1, 16'd0);
    run("m2_flip", 2'd2, 32'h0000_3000, 4'd1, 0, 1, 5, 16'd1);

    run("m0_stall", 2'd0, 32'h0000_2000, 4'd2, 20, 6, 2, 16'd0);
    check("m0_max_outst", max_ar_outst, 2);
    check("m0_araddr_stable", stab_err, 0);

    run("m2_wrap", 2'd2, 32'hFFFF_FFC0, 4'd0, 0, 0, -1, 16'd0);
    check("wrap_second_addr", aw_log[1], 32'h0000_0000);

    run("m3_reserved", 2'd3, 32'h0000_0000, 4'd0, 0, 0, -1, 16'd0);

    reset_midrun();
    run("m2_after_rst", 2'd2, 32'h0000_5000, 4'd3, 0, 3, -1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
